// File: rtl/fetch_sequencer.sv
// Instruction fetch front-end: PC, req/ack program-memory fetch and prefetch FIFO feeding the IR.
// Define FETCH_PERF_EN to add the empty_cycles performance counter output.
module fetch_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_data,
   output logic              instr_valid,
   output logic [7:0]        instruction,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              LoadIR,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] pc
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       empty_cycles
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DISCARD
   } fetchState_t;

   fetchState_t state, stateNext;

   logic [ADDR_W-1:0] pcReg, pcNext;
   logic [ADDR_W-1:0] addrReg, addrNext;
   logic [CNT_W-1:0]  count, nextCount;
   logic [PTR_W-1:0]  rdPtr, wrPtr;
   logic [7:0]        dataMem [DEPTH];
   logic [ADDR_W-1:0] addrMem [DEPTH];
   logic              push, pop, flush;

   assign instr_valid = (count != '0);
   assign instruction = instr_valid ? dataMem[rdPtr] : '0;
   assign instr_pc    = instr_valid ? addrMem[rdPtr] : '0;
   assign mem_req     = (state == FETCH) || (state == DISCARD);
   assign mem_addr    = addrReg;
   assign pc          = pcReg;

   // A jump overrides everything, so a pop in the jump cycle is suppressed.
   assign pop = LoadIR && instr_valid && !jump;

   always_comb begin
      stateNext = state;
      pcNext    = pcReg;
      addrNext  = addrReg;
      push      = 1'b0;
      flush     = 1'b0;
      nextCount = count + CNT_W'(1) - CNT_W'(pop);
      unique case (state)
         IDLE: begin
            if (jump) begin
               flush     = 1'b1;
               pcNext    = jump_addr;
               addrNext  = jump_addr;
               stateNext = FETCH;
            end else if (count < FULL) begin
               addrNext  = pcReg;
               stateNext = FETCH;
            end
         end
         FETCH: begin
            if (jump) begin
               flush  = 1'b1;
               pcNext = jump_addr;
               // Without an ack the old request must stay on the bus until it completes.
               if (mem_ack) begin
                  addrNext = jump_addr;
               end else begin
                  stateNext = DISCARD;
               end
            end else if (mem_ack) begin
               push   = 1'b1;
               pcNext = pcReg + ADDR_W'(1);
               if (nextCount < FULL) begin
                  addrNext = pcReg + ADDR_W'(1);
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         DISCARD: begin
            if (jump) begin
               flush  = 1'b1;
               pcNext = jump_addr;
            end else if (mem_ack) begin
               addrNext  = pcReg;
               stateNext = FETCH;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         pcReg   <= RESET_PC;
         addrReg <= '0;
         count   <= '0;
         rdPtr   <= '0;
         wrPtr   <= '0;
      end else begin
         state   <= stateNext;
         pcReg   <= pcNext;
         addrReg <= addrNext;
         if (flush) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
         end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
               wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
               rdPtr <= rdPtr + PTR_W'(1);
            end
         end
      end
   end

   // Storage needs no reset; the count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         dataMem[wrPtr] <= mem_data;
         addrMem[wrPtr] <= addrReg;
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         empty_cycles <= '0;
      end else if (!instr_valid && (empty_cycles != 16'hFFFF)) begin
         empty_cycles <= empty_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized stream
// checked against an address-stream reference model.
module tb_fetch_sequencer;

   localparam logic [7:0] RPC = 8'hFE;

   logic       clk;
   logic       reset;
   logic       memReq;
   logic [7:0] memAddr;
   logic       memAck;
   logic [7:0] memData;
   logic       instrValid;
   logic [7:0] instruction;
   logic [7:0] instrPc;
   logic       loadIR;
   logic       jump;
   logic [7:0] jumpAddr;
   logic [7:0] pc;
`ifdef FETCH_PERF_EN
   logic [15:0] emptyCycles;
`endif

   int checks;
   int failures;
   logic [7:0] memImage [256];

   fetch_sequencer #(
      .ADDR_W(8),
      .DEPTH(2),
      .RESET_PC(RPC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mem_req(memReq),
      .mem_addr(memAddr),
      .mem_ack(memAck),
      .mem_data(memData),
      .instr_valid(instrValid),
      .instruction(instruction),
      .instr_pc(instrPc),
      .LoadIR(loadIR),
      .jump(jump),
      .jump_addr(jumpAddr),
      .pc(pc)
`ifdef FETCH_PERF_EN
      ,
      .empty_cycles(emptyCycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model serves the currently requested address, then one clock edge passes.
   task automatic tick;
      memData = memImage[memAddr];
      @(negedge clk);
   endtask

   task automatic doReset;
      reset = 1'b0;
      memAck = 1'b0;
      loadIR = 1'b0;
      jump = 1'b0;
      jumpAddr = 8'h00;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset;
      doReset();
      checks++; if (memReq !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req got %0b want 0", memReq); end
      checks++; if (memAddr !== 8'h00) begin failures++; $display("[TB] FAIL reset_mem_addr got %h want 00", memAddr); end
      checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %0b want 0", instrValid); end
      checks++; if (instruction !== 8'h00) begin failures++; $display("[TB] FAIL reset_instruction got %h want 00", instruction); end
      checks++; if (instrPc !== 8'h00) begin failures++; $display("[TB] FAIL reset_instr_pc got %h want 00", instrPc); end
      checks++; if (pc !== RPC) begin failures++; $display("[TB] FAIL reset_pc got %h want %h", pc, RPC); end
   endtask

   task automatic test_first_fetch;
      logic [7:0] a0, a1, a2;
      a0 = RPC;
      a1 = a0 + 8'd1;
      a2 = a0 + 8'd2;
      memAck = 1'b1;
      tick();
      checks++; if (memReq !== 1'b1) begin failures++; $display("[TB] FAIL first_req got %0b want 1", memReq); end
      checks++; if (memAddr !== a0) begin failures++; $display("[TB] FAIL first_addr0 got %h want %h", memAddr, a0); end
      tick();
      checks++; if (memAddr !== a1) begin failures++; $display("[TB] FAIL first_addr1 got %h want %h", memAddr, a1); end
      checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL first_latency got %0b want 1", instrValid); end
      tick();
      tick();
      checks++; if (memReq !== 1'b0) begin failures++; $display("[TB] FAIL first_full_req got %0b want 0", memReq); end
      checks++; if (instruction !== memImage[a0]) begin failures++; $display("[TB] FAIL first_instr got %h want %h", instruction, memImage[a0]); end
      checks++; if (instrPc !== a0) begin failures++; $display("[TB] FAIL first_instr_pc got %h want %h", instrPc, a0); end
      checks++; if (pc !== a2) begin failures++; $display("[TB] FAIL first_pc got %h want %h", pc, a2); end
      memAck = 1'b0;
   endtask

   task automatic test_stream;
      int n;
      logic [7:0] e;
      doReset();
      memAck = 1'b1;
      loadIR = 1'b1;
      n = 0;
      while (!instrValid && n < 10) begin
         tick();
         n++;
      end
      checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL stream_start got %0b want 1 after %0d cycles", instrValid, n); end
      e = RPC;
      for (int i = 0; i < 6; i++) begin
         checks++; if (instrValid !== 1'b1) begin failures++; $display("[TB] FAIL stream_bubble[%0d] got %0b want 1", i, instrValid); end
         checks++; if (instrPc !== e) begin failures++; $display("[TB] FAIL stream_pc[%0d] got %h want %h", i, instrPc, e); end
         checks++; if (instruction !== memImage[e]) begin failures++; $display("[TB] FAIL stream_data[%0d] got %h want %h", i, instruction, memImage[e]); end
         e = e + 8'd1;
         tick();
      end
      loadIR = 1'b0;
      memAck = 1'b0;
   endtask

   task automatic test_jump_discard;
      logic [7:0] t;
      t = 8'h40;
      doReset();
      jump = 1'b1;
      jumpAddr = 8'h05;
      tick();
      checks++; if (memAddr !== 8'h05) begin failures++; $display("[TB] FAIL disc_addr got %h want 05", memAddr); end
      checks++; if (memReq !== 1'b1) begin failures++; $display("[TB] FAIL disc_req got %0b want 1", memReq); end
      jumpAddr = t;
      tick();
      jump = 1'b0;
      checks++; if (pc !== t) begin failures++; $display("[TB] FAIL disc_pc got %h want %h", pc, t); end
      checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL disc_valid got %0b want 0", instrValid); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (memAddr !== 8'h05 || memReq !== 1'b1) begin failures++; $display("[TB] FAIL disc_hold[%0d] got req %0b addr %h want 1 05", i, memReq, memAddr); end
         if (i < 2) tick();
      end
      memAck = 1'b1;
      tick();
      checks++; if (memAddr !== t) begin failures++; $display("[TB] FAIL disc_redirect got %h want %h", memAddr, t); end
      checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL disc_dropped got %0b want 0", instrValid); end
      tick();
      checks++; if (instrValid !== 1'b1 || instrPc !== t) begin failures++; $display("[TB] FAIL disc_first got valid %0b pc %h want 1 %h", instrValid, instrPc, t); end
      checks++; if (instruction !== memImage[t]) begin failures++; $display("[TB] FAIL disc_data got %h want %h", instruction, memImage[t]); end
      memAck = 1'b0;
   endtask

   task automatic test_jump_flush;
      logic [7:0] ja;
      doReset();
      memAck = 1'b1;
      repeat (4) tick();
      checks++; if (instrValid !== 1'b1 || memReq !== 1'b0) begin failures++; $display("[TB] FAIL flush_full got valid %0b req %0b want 1 0", instrValid, memReq); end
      ja = 8'($urandom);
      jumpAddr = ja;
      jump = 1'b1;
      loadIR = 1'b1;
      memAck = 1'b0;
      tick();
      jump = 1'b0;
      loadIR = 1'b0;
      checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got %0b want 0", instrValid); end
      checks++; if (pc !== ja) begin failures++; $display("[TB] FAIL flush_pc got %h want %h", pc, ja); end
      checks++; if (memAddr !== ja || memReq !== 1'b1) begin failures++; $display("[TB] FAIL flush_req got req %0b addr %h want 1 %h", memReq, memAddr, ja); end
      memAck = 1'b1;
      tick();
      checks++; if (instrValid !== 1'b1 || instrPc !== ja) begin failures++; $display("[TB] FAIL flush_first got valid %0b pc %h want 1 %h", instrValid, instrPc, ja); end
      tick();
      checks++; if (instrPc !== ja || instruction !== memImage[ja]) begin failures++; $display("[TB] FAIL flush_head got pc %h data %h want %h %h", instrPc, instruction, ja, memImage[ja]); end
      memAck = 1'b0;
   endtask

   task automatic test_reset_midrequest;
      doReset();
      tick();
      tick();
      checks++; if (memReq !== 1'b1) begin failures++; $display("[TB] FAIL mid_outstanding got %0b want 1", memReq); end
      reset = 1'b0;
      tick();
      checks++; if (memReq !== 1'b0 || instrValid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset got req %0b valid %0b want 0 0", memReq, instrValid); end
      reset = 1'b1;
      memAck = 1'b1;
      tick();
      checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL mid_late_ack got %0b want 0", instrValid); end
      checks++; if (memReq !== 1'b1 || memAddr !== RPC) begin failures++; $display("[TB] FAIL mid_restart got req %0b addr %h want 1 %h", memReq, memAddr, RPC); end
      memAck = 1'b0;
   endtask

   // Reference model: the popped stream must walk consecutive addresses from the reset PC
   // or the latest jump target, each byte equal to memory at that address.
   task automatic test_random;
      logic [7:0] expPc;
      logic [7:0] prevAddr;
      logic       prevReq, prevAck, expectEmpty;
      int         pops;
      doReset();
      expPc = RPC;
      prevReq = 1'b0;
      prevAck = 1'b0;
      prevAddr = 8'h00;
      expectEmpty = 1'b0;
      pops = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (prevReq && !prevAck) begin
            checks++; if (memReq !== 1'b1 || memAddr !== prevAddr) begin failures++; $display("[TB] FAIL rnd_hold[%0d] got req %0b addr %h want 1 %h", cyc, memReq, memAddr, prevAddr); end
         end
         if (expectEmpty) begin
            checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL rnd_flush[%0d] got %0b want 0", cyc, instrValid); end
         end
         if (instrValid) begin
            checks++; if (instrPc !== expPc) begin failures++; $display("[TB] FAIL rnd_pc[%0d] got %h want %h", cyc, instrPc, expPc); end
            checks++; if (instruction !== memImage[expPc]) begin failures++; $display("[TB] FAIL rnd_data[%0d] got %h want %h", cyc, instruction, memImage[expPc]); end
         end else begin
            checks++; if (instruction !== 8'h00 || instrPc !== 8'h00) begin failures++; $display("[TB] FAIL rnd_empty[%0d] got %h %h want 00 00", cyc, instruction, instrPc); end
         end
         memAck = memReq && ($urandom_range(0, 2) != 0);
         loadIR = 1'($urandom_range(0, 1));
         jump = ($urandom_range(0, 19) == 0);
         jumpAddr = 8'($urandom);
         if (jump) begin
            expPc = jumpAddr;
            expectEmpty = 1'b1;
         end else begin
            expectEmpty = 1'b0;
            if (loadIR && instrValid) begin
               expPc = expPc + 8'd1;
               pops++;
            end
         end
         prevReq = memReq;
         prevAck = memAck;
         prevAddr = memAddr;
         tick();
      end
      checks++; if (pops < 20) begin failures++; $display("[TB] FAIL rnd_progress got %0d pops want at least 20", pops); end
      memAck = 1'b0;
      loadIR = 1'b0;
      jump = 1'b0;
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf;
      int expEmpty;
      doReset();
      checks++; if (emptyCycles !== 16'd0) begin failures++; $display("[TB] FAIL perf_clear got %0d want 0", emptyCycles); end
      // Ten cycles without ack (including the post-reset idle cycle) plus the ack cycle itself.
      expEmpty = 0;
      repeat (10) begin
         tick();
         expEmpty++;
      end
      memAck = 1'b1;
      tick();
      expEmpty++;
      memAck = 1'b0;
      checks++; if (emptyCycles !== 16'(expEmpty)) begin failures++; $display("[TB] FAIL perf_count got %0d want %0d", emptyCycles, expEmpty); end
      repeat (3) tick();
      checks++; if (emptyCycles !== 16'(expEmpty) || instrValid !== 1'b1) begin failures++; $display("[TB] FAIL perf_stop got %0d valid %0b want %0d 1", emptyCycles, instrValid, expEmpty); end
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      memAck = 1'b0;
      memData = 8'h00;
      loadIR = 1'b0;
      jump = 1'b0;
      jumpAddr = 8'h00;
      for (int i = 0; i < 256; i++) memImage[i] = 8'($urandom);
      test_reset();
      test_first_fetch();
      test_stream();
      test_jump_discard();
      test_jump_flush();
      test_reset_midrequest();
      test_random();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
